// File: rtl/vector_element_sequencer_if.sv
// Handshake bundle between the control unit (master) and the element sequencer (slave).
// Valid/ready semantics: an element is offered while elem_valid=1 and is accepted on a rising edge with stall=0.
interface vector_element_sequencer_if #(parameter int N = 6);
    logic         start;
    logic         op_type;
    logic [N-1:0] vector_max;
    logic         stall;
    logic         ack;
    logic [N-1:0] counter;
    logic         elem_valid;
    logic         elem_last;
    logic         busy;
    logic         finished;

    modport master (
        output start, op_type, vector_max, stall, ack,
        input  counter, elem_valid, elem_last, busy, finished
    );

    modport slave (
        input  start, op_type, vector_max, stall, ack,
        output counter, elem_valid, elem_last, busy, finished
    );
endinterface

// File: rtl/vector_element_sequencer.sv
// Issues element indices 1..limit for one scalar or vector op, then holds a sticky
// finished until the controller acknowledges it. All outputs come straight from flops.
module vector_element_sequencer #(
    parameter int N = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    vector_element_sequencer_if.slave    bus,
    output logic [1:0]                   dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    logic [N-1:0] limit;
    logic [N-1:0] counter_q;
    logic [N-1:0] counter_inc;
    logic [N-1:0] start_limit;
    logic         valid_q;
    logic         last_q;
    logic         busy_q;
    logic         finished_q;

    // A zero-length vector op still processes one element.
    always_comb begin
        start_limit = ONE;
        if (bus.op_type && (bus.vector_max != '0))
            start_limit = bus.vector_max;
    end

    assign counter_inc = counter_q + ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            limit      <= '0;
            counter_q  <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        limit     <= start_limit;
                        counter_q <= ONE;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        last_q    <= (start_limit == ONE);
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (counter_q == limit) begin
                            state      <= DONE;
                            finished_q <= 1'b1;
                            valid_q    <= 1'b0;
                            last_q     <= 1'b0;
                        end else begin
                            counter_q <= counter_inc;
                            last_q    <= (counter_inc == limit);
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here, even alongside ack.
                    if (bus.ack) begin
                        state      <= IDLE;
                        counter_q  <= '0;
                        finished_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    counter_q  <= '0;
                    valid_q    <= 1'b0;
                    last_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    finished_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.counter    = counter_q;
    assign bus.elem_valid = valid_q;
    assign bus.elem_last  = last_q;
    assign bus.busy       = busy_q;
    assign bus.finished   = finished_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_vector_element_sequencer.sv
// Self-checking bench for vector_element_sequencer: directed vector tables, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_vector_element_sequencer;
    localparam int N = 6;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         tests_run;
    int         tests_failed;

    vector_element_sequencer_if #(.N(N)) bus ();

    vector_element_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the elements still to be issued, plus a waiting-for-ack flag.
    logic [N-1:0] exp_q[$];
    logic         m_wait;
    int           m_len;

    typedef struct {
        logic         s;
        logic         op;
        logic [N-1:0] vm;
        logic         st;
        logic         a;
        logic [N-1:0] cnt;
        logic         v;
        logic         l;
        logic         b;
        logic         f;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic s, input logic op, input int vm, input logic st,
                                input logic a, input int cnt, input logic v, input logic l,
                                input logic b, input logic f);
        vec_t r;
        r.s = s; r.op = op; r.vm = N'(vm); r.st = st; r.a = a;
        r.cnt = N'(cnt); r.v = v; r.l = l; r.b = b; r.f = f;
        tbl.push_back(r);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_wait = 1'b0;
        m_len  = 0;
    endfunction

    function automatic void model_step(input logic s, input logic op, input logic [N-1:0] vm,
                                       input logic st, input logic a);
        if (m_wait) begin
            if (a) m_wait = 1'b0;
        end else if (exp_q.size() > 0) begin
            if (!st) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_wait = 1'b1;
            end
        end else if (s) begin
            m_len = (op && vm != 0) ? int'(vm) : 1;
            for (int i = 1; i <= m_len; i++) exp_q.push_back(N'(i));
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input logic v, input logic l,
                             input logic b, input logic f);
        check({tag, ".counter"},    int'(bus.counter),    cnt);
        check({tag, ".elem_valid"}, int'(bus.elem_valid), int'(v));
        check({tag, ".elem_last"},  int'(bus.elem_last),  int'(l));
        check({tag, ".busy"},       int'(bus.busy),       int'(b));
        check({tag, ".finished"},   int'(bus.finished),   int'(f));
    endtask

    task automatic check_model(input string tag);
        int ec;
        if (exp_q.size() > 0) ec = int'(exp_q[0]);
        else if (m_wait)      ec = m_len;
        else                  ec = 0;
        check_all(tag, ec, exp_q.size() > 0, exp_q.size() == 1,
                  (exp_q.size() > 0) || m_wait, m_wait);
    endtask

    // Apply inputs before the edge, advance the model, then sample 1ns after the edge.
    task automatic drive(input logic s, input logic op, input logic [N-1:0] vm,
                         input logic st, input logic a);
        bus.start = s; bus.op_type = op; bus.vector_max = vm; bus.stall = st; bus.ack = a;
        model_step(s, op, vm, st, a);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        model_reset();
        bus.start = 0; bus.op_type = 0; bus.vector_max = '0; bus.stall = 0; bus.ack = 0;

        // Reset then idle
        rst = 1'b0;
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            check_all("idle", 0, 0, 0, 0, 0);
        end

        // Scalar op, vector op with stalls and ignored commands, zero-length vector op
        add(1, 0, 20, 0, 0,   1, 1, 1, 1, 0);
        add(0, 0,  0, 0, 0,   1, 0, 0, 1, 1);
        add(0, 0,  0, 0, 0,   1, 0, 0, 1, 1);
        add(0, 0,  0, 0, 1,   0, 0, 0, 0, 0);
        add(1, 1,  5, 0, 0,   1, 1, 0, 1, 0);
        add(0, 0,  0, 0, 0,   2, 1, 0, 1, 0);
        add(1, 0,  1, 0, 0,   3, 1, 0, 1, 0);
        add(0, 0,  0, 1, 0,   3, 1, 0, 1, 0);
        add(0, 0,  0, 1, 0,   3, 1, 0, 1, 0);
        add(0, 0,  0, 0, 0,   4, 1, 0, 1, 0);
        add(0, 0,  0, 0, 0,   5, 1, 1, 1, 0);
        add(0, 0,  0, 0, 0,   5, 0, 0, 1, 1);
        add(1, 1,  9, 0, 0,   5, 0, 0, 1, 1);
        add(1, 1,  9, 0, 1,   0, 0, 0, 0, 0);
        add(0, 1,  9, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1,  0, 0, 0,   1, 1, 1, 1, 0);
        add(0, 0,  0, 0, 0,   1, 0, 0, 1, 1);
        add(0, 0,  0, 0, 1,   0, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].s, tbl[i].op, tbl[i].vm, tbl[i].st, tbl[i].a);
            check_all($sformatf("vec%0d", i), int'(tbl[i].cnt), tbl[i].v, tbl[i].l,
                      tbl[i].b, tbl[i].f);
        end

        // Full-range vector op counts to all-ones without wrapping
        drive(1'b1, 1'b1, 6'd63, 1'b0, 1'b0);
        for (int i = 1; i <= 63; i++) begin
            check_all($sformatf("max%0d", i), i, 1'b1, i == 63, 1'b1, 1'b0);
            if (i < 63) idle_cycle();
        end
        idle_cycle();
        check_all("max_done", 63, 0, 0, 1, 1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_all("max_ack", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-operation
        drive(1'b1, 1'b1, 6'd10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle_cycle();
        check_all("pre_abort", 4, 1, 0, 1, 0);
        #3;
        rst = 1'b0;
        #1;
        check_all("abort_async", 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            idle_cycle();
            check_all("post_abort", 0, 0, 0, 0, 0);
        end

        // Random traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] vm;
            vm = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 63))
                                             : N'($urandom_range(0, 6));
            drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), vm,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 2) == 0);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
